// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I instruction fetch stage with req/gnt/rvalid port and 2-entry fetch FIFO
module if_stage #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_set_i,
    input  logic [3:0]  pc_mux_i,
    input  logic [31:0] jump_target_i,
    input  logic [31:0] branch_target_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        instr_valid_id_o,
    output logic [31:0] instr_rdata_id_o,
    output logic [31:0] pc_id_o,
    input  logic        id_ready_i
);

    localparam logic [3:0]  PC_BOOT   = 4'b0000;
    localparam logic [3:0]  PC_JUMP   = 4'b0010;
    localparam logic [3:0]  PC_BRANCH = 4'b0011;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_REQ,
        ST_WAIT_RVALID
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q;
    logic        req_hold_q;
    logic [31:0] addr_hold_q;
    logic        stale_q;
    logic        discard_q;
    logic [31:0] resp_pc_q;

    logic [31:0] fifo_pc_q    [2];
    logic [31:0] fifo_instr_q [2];
    logic        rd_ptr_q, wr_ptr_q;
    logic [1:0]  count_q;

    logic        mux_valid;
    logic [31:0] redirect_target;
    logic        redirect;
    logic        outstanding;
    logic        rvalid_ok;
    logic        gnt_ok;
    logic        handshake;
    logic        pop;
    logic        push;
    logic [2:0]  occupancy;
    logic        req_en;
    logic        req;

    // Decode the pc-mux code; unknown codes turn the redirect strobe into a no-op
    always_comb begin
        mux_valid       = 1'b1;
        redirect_target = BOOT_ADDR;
        case (pc_mux_i)
            PC_BOOT:   redirect_target = BOOT_ADDR;
            PC_JUMP:   redirect_target = jump_target_i;
            PC_BRANCH: redirect_target = branch_target_i;
            default:   mux_valid = 1'b0;
        endcase
    end

    assign redirect    = pc_set_i & mux_valid;
    assign outstanding = (state_q == ST_WAIT_RVALID);
    assign rvalid_ok   = instr_rvalid_i & outstanding;
    assign gnt_ok      = instr_req_o & instr_gnt_i;
    assign handshake   = instr_valid_id_o & id_ready_i;
    // ID must not consume during a redirect, so the head is kept (and then flushed)
    assign pop         = handshake & ~redirect;
    assign push        = rvalid_ok & ~discard_q & ~redirect;

    // Slots already committed (buffered + in flight) must leave room for one more
    assign occupancy   = {1'b0, count_q} + {2'b00, outstanding} - {2'b00, pop};
    assign req_en      = (occupancy < 3'd2) & (~outstanding | instr_rvalid_i);

    assign instr_req_o  = req;
    // A request that was not yet granted keeps its original address, even across a redirect
    assign instr_addr_o = req_hold_q ? addr_hold_q : fetch_pc_q;

    assign instr_valid_id_o = (count_q != 2'd0);
    assign instr_rdata_id_o = fifo_instr_q[rd_ptr_q];
    assign pc_id_o          = fifo_pc_q[rd_ptr_q];

    // Fetch FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch FSM next state and request generation
    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        case (state_q)
            ST_RESET: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                req = req_hold_q | req_en;
                if (req && instr_gnt_i) begin
                    state_d = ST_WAIT_RVALID;
                end
            end
            ST_WAIT_RVALID: begin
                req = req_en;
                if (instr_rvalid_i) begin
                    state_d = (req && instr_gnt_i) ? ST_WAIT_RVALID : ST_REQ;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Fetch PC, held-request tracking and response discard bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q  <= BOOT_ADDR;
            req_hold_q  <= 1'b0;
            addr_hold_q <= BOOT_ADDR;
            stale_q     <= 1'b0;
            discard_q   <= 1'b0;
            resp_pc_q   <= BOOT_ADDR;
        end else begin
            req_hold_q  <= instr_req_o & ~instr_gnt_i;
            addr_hold_q <= instr_addr_o;

            if (gnt_ok) begin
                resp_pc_q <= instr_addr_o;
            end

            // A stale held request does not advance the PC; the target is already loaded
            if (redirect) begin
                fetch_pc_q <= redirect_target & ~32'h0000_0003;
            end else if (gnt_ok && !stale_q) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end

            if (gnt_ok) begin
                stale_q <= 1'b0;
            end else if (redirect && instr_req_o) begin
                stale_q <= 1'b1;
            end

            // Only one response can be in flight, so a single flag covers it
            if (redirect && ((outstanding && !instr_rvalid_i) || gnt_ok)) begin
                discard_q <= 1'b1;
            end else if (gnt_ok && stale_q) begin
                discard_q <= 1'b1;
            end else if (rvalid_ok) begin
                discard_q <= 1'b0;
            end
        end
    end

    // Two-entry FIFO of {pc, instr}; a redirect flushes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_pc_q[i]    <= 32'h0000_0000;
                fifo_instr_q[i] <= NOP_INSTR;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (redirect) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
                fifo_instr_q[wr_ptr_q] <= instr_rdata_i;
                wr_ptr_q               <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage RV32I pipeline. It sits directly upstream of the ID stage. It owns the fetch PC and selects redirect targets using the pc-mux codes `PC_BOOT`, `PC_JUMP` and `PC_BRANCH`. It drives a req/gnt/rvalid instruction-memory port and buffers returned instructions with their PCs in a 2-entry FIFO that feeds ID through a valid/ready handshake.

## Interface
- `BOOT_ADDR`, default 32'h0000_0000: first fetch address after reset, and the `PC_BOOT` target.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `pc_set_i`  in  1  redirect strobe, one cycle per redirect.
- `pc_mux_i`  in  4  target select: `PC_BOOT` / `PC_JUMP` / `PC_BRANCH`. Any other code makes `pc_set_i` ignored.
- `jump_target_i`  in  32  JAL/JALR target.
- `branch_target_i`  in  32  taken-branch target.
- `instr_req_o`  out  1  fetch request.
- `instr_addr_o`  out  32  fetch address, word aligned.
- `instr_gnt_i`  in  1  request accepted this cycle.
- `instr_rvalid_i`  in  1  response data valid.
- `instr_rdata_i`  in  32  response instruction.
- `instr_valid_id_o`  out  1  FIFO head valid toward ID.
- `instr_rdata_id_o`  out  32  FIFO head instruction.
- `pc_id_o`  out  32  FIFO head PC.
- `id_ready_i`  in  1  ID accepts the head this cycle. Handshake = `instr_valid_id_o & id_ready_i`.

## Operation
- **Fetch PC.**
  - `fetch_pc` resets to `BOOT_ADDR`.
  - It increments by 4 on each granted request that is not redirected in the same cycle.
  - Redirect target: `PC_BOOT` → `BOOT_ADDR`, `PC_JUMP` → `jump_target_i`, `PC_BRANCH` → `branch_target_i`.
  - Bits [1:0] of the target are forced to 0.
- **Memory protocol.**
  - At most 1 granted-but-unreturned request is outstanding.
  - Once `instr_req_o` rises, it and `instr_addr_o` hold stable until `instr_gnt_i`.
  - `rvalid` arrives at the earliest 1 cycle after `gnt`, strictly in order.
- **Request enable.**
  - A new request needs `fifo_count + outstanding - handshake_this_cycle < 2`.
  - It also needs no outstanding request, or the outstanding one returning (`rvalid`) this cycle.
- **Fetch FSM.**
  - States: `RESET` → `REQ` → `WAIT_RVALID`.
  - `RESET`: occupied for the first cycle after `rst_n` deasserts; `instr_req_o` = 0. Next state is `REQ`.
  - `REQ`: `instr_req_o` = request enable, or 1 if the request was already asserted. On `gnt`, go to `WAIT_RVALID`.
  - `WAIT_RVALID`: on `rvalid` with a new `gnt` in the same cycle, stay. On `rvalid` alone, go to `REQ`.
- **FIFO.**
  - 2 entries of {pc, instr}, registered storage.
  - Head drives `instr_valid_id_o`, `instr_rdata_id_o` and `pc_id_o` directly.
  - Push on `rvalid` unless the response is marked discard. Pop on handshake.
  - Simultaneous push and pop keep the count unchanged. Push is never attempted when full; the request-enable rule guarantees this.
- **Redirect** (`pc_set_i` with a valid code):
  - The FIFO is cleared at the next edge. Any handshake in that cycle is ignored; ID must treat the redirect cycle as a non-consume.
  - If a request is outstanding, or granted in this cycle, its response is dropped via the `discard` flag. The flag clears on that `rvalid`.
  - An `rvalid` arriving in the redirect cycle itself is dropped.
  - If `instr_req_o` is asserted without `gnt`, it stays asserted with the old address. Its response is discarded and the target is fetched next.
  - `fetch_pc` takes the target. The next issued request uses the target address.
  - Two redirects back-to-back: the last one wins.

## Timing
- Reset values:
  - `instr_req_o` = 0, `instr_addr_o` = `BOOT_ADDR`.
  - `instr_valid_id_o` = 0, `instr_rdata_id_o` = 32'h0000_0013 (NOP), `pc_id_o` = 0.
  - FIFO empty, `discard` = 0, FSM in `RESET`.
- First `instr_req_o` rises 1 cycle after `rst_n` deasserts.
- Latency: with `gnt` in cycle t and `rvalid` in t+1, `instr_valid_id_o` rises in cycle t+2.
- Steady-state throughput is 1 instruction per cycle when `gnt` is same-cycle, `rvalid` is next-cycle and `id_ready_i` = 1.
- After redirect in cycle r with no request pending: request to the target in r+1. That instruction is valid at ID no earlier than r+3.
- `rst_n` asserted mid-transaction clears all state immediately. Any late `rvalid` after reset release is ignored, because outstanding = 0 and `rvalid` with outstanding = 0 is dropped.

## Test plan
- **Boot stream:** `BOOT_ADDR` = 0x100, `gnt` same cycle, `rvalid` next cycle, `id_ready_i` = 1 → addresses 0x100, 0x104, 0x108… one per cycle. ID sees `pc_id_o` 0x100 with valid 2 cycles after the first request.
- **Backpressure:** `id_ready_i` = 0 for 5 cycles → exactly 2 instructions buffered, `instr_req_o` = 0 after the second `gnt`. On release, PCs reach ID in order with no loss or duplication.
- **Redirect with outstanding response:** `PC_JUMP`, `jump_target_i` = 0x2002, while a request to 0x10C is awaiting `rvalid` → the 0x10C response is dropped, FIFO empty, next `instr_addr_o` = 0x2000.
- **Redirect while waiting for gnt:** `PC_BRANCH` to 0x400 while `req` is held with addr 0x108 and `gnt` withheld 3 cycles → addr stays 0x108 until `gnt`, its data is discarded, next request 0x400.
- **Invalid code and double redirect:** `pc_set_i` with `pc_mux_i` = 4'b0001 → no effect. `PC_JUMP` 0x500 followed next cycle by `PC_BRANCH` 0x600 → only 0x600 is fetched.
- **Reset mid-operation:** `rst_n` low for 2 cycles while the FIFO holds 2 entries and one request is outstanding → all outputs return to reset values. A stray `rvalid` after release is ignored. Fetch restarts at `BOOT_ADDR`.
